// File: rtl/ysyx_23060236_clint_mt.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_clint_mt
//
// Multi-hart core-local interruptor on an AXI4-Lite slave port.
// Holds a free-running 64-bit mtime with a programmable prescaler, one
// 64-bit mtimecmp and one msip bit per hart, and drives per-hart timer
// (mtip) and software (msip) interrupt levels.
//
// Register map (addr[15:0], upper address bits ignored, word aligned):
//   0x0000 + 4*h        msip[h]          (bit 0 only)
//   0x4000 + 8*h        mtimecmp[h] low word
//   0x4004 + 8*h        mtimecmp[h] high word
//   0xBFF8 / 0xBFFC     mtime low / high word
// Unmapped addresses and harts >= NHART answer SLVERR (rdata 0) and a write
// to them changes nothing.
//
// Parameters:
//   NHART  number of harts served (1..4)
//   DIV    clock cycles per mtime increment (1..256)
//
// Configuration macro:
//   YSYX_23060236_CLINT_MTIME_WR_EN  when defined mtime is writable from the
//   bus (write beats the same-cycle increment and clears the prescaler);
//   when undefined mtime writes answer SLVERR and leave mtime untouched.
//
// Ports:
//   clock                  sole clock, rising edge
//   reset                  asynchronous, active-low
//   araddr/arvalid/arready read address channel
//   rdata/rresp/rvalid/rready read data channel
//   awaddr/awvalid/awready, wdata/wstrb/wvalid/wready  write channels
//   bresp/bvalid/bready    write response channel
//   mtip[NHART-1:0]        timer interrupt levels (registered compare)
//   msip[NHART-1:0]        software interrupt levels
// ---------------------------------------------------------------------------
module ysyx_23060236_clint_mt #(
  parameter int NHART = 1,
  parameter int DIV   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [31:0]       awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic [NHART-1:0]  mtip,
  output logic [NHART-1:0]  msip
);

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } reg_kind_t;

  typedef struct packed {
    reg_kind_t  kind;
    logic [1:0] hart;
    logic       hi;
  } reg_sel_t;

  localparam logic [7:0] DIV_LAST    = 8'(DIV - 1);
  localparam logic [2:0] HART_LIMIT  = 3'(NHART);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address decode shared by both channels. Harts beyond NHART decode to
  // REG_NONE so they fall into the SLVERR path automatically.
  function automatic reg_sel_t decode(input logic [15:0] addr);
    reg_sel_t sel;
    sel.kind = REG_NONE;
    sel.hart = 2'd0;
    sel.hi   = 1'b0;
    if (addr[1:0] == 2'b00) begin
      if (addr[15:4] == 12'h000) begin
        sel.hart = addr[3:2];
        if ({1'b0, addr[3:2]} < HART_LIMIT) sel.kind = REG_MSIP;
      end else if (addr[15:5] == 11'h200) begin
        sel.hart = addr[4:3];
        sel.hi   = addr[2];
        if ({1'b0, addr[4:3]} < HART_LIMIT) sel.kind = REG_MTIMECMP;
      end else if (addr[15:3] == 13'h17FF) begin
        sel.kind = REG_MTIME;
        sel.hi   = addr[2];
      end
    end
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  r_state_t          r_state_reg, r_state_next;
  w_state_t          w_state_reg, w_state_next;
  logic [63:0]       mtime_reg, mtime_next;
  logic [7:0]        presc_reg, presc_next;
  logic [63:0]       mtimecmp_reg  [NHART];
  logic [63:0]       mtimecmp_next [NHART];
  logic [NHART-1:0]  msip_reg, msip_next;
  logic [NHART-1:0]  mtip_reg, mtip_hit;
  logic [31:0]       rdata_reg;
  logic [1:0]        rresp_reg, bresp_reg;

  reg_sel_t          rd_sel, wr_sel;
  logic [31:0]       rd_word;
  logic              rd_ok, wr_ok;
  logic              rd_fire, wr_fire;

  // Only addr[15:0] takes part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[31:16], awaddr[31:16]};

  assign rd_fire = (r_state_reg == R_IDLE) && arvalid;
  assign wr_fire = (w_state_reg == W_IDLE) && awvalid && wvalid;

  // ---------------- read path ----------------
  // rd_word reflects register contents before this cycle's write, so a
  // read colliding with a write to the same register returns the old value.
  always_comb begin
    rd_sel  = decode(araddr[15:0]);
    rd_word = '0;
    rd_ok   = 1'b1;
    case (rd_sel.kind)
      REG_MSIP: begin
        for (int h = 0; h < NHART; h++) begin
          if (rd_sel.hart == 2'(h)) rd_word = {31'd0, msip_reg[h]};
        end
      end
      REG_MTIMECMP: begin
        for (int h = 0; h < NHART; h++) begin
          if (rd_sel.hart == 2'(h)) begin
            rd_word = rd_sel.hi ? mtimecmp_reg[h][63:32] : mtimecmp_reg[h][31:0];
          end
        end
      end
      REG_MTIME: rd_word = rd_sel.hi ? mtime_reg[63:32] : mtime_reg[31:0];
      default:   rd_ok = 1'b0;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (arvalid) r_state_next = R_RESP;
      R_RESP:  if (rready)  r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // ---------------- write path ----------------
  always_comb begin
    wr_sel = decode(awaddr[15:0]);
    wr_ok  = 1'b0;
    case (wr_sel.kind)
      REG_MSIP:     wr_ok = 1'b1;
      REG_MTIMECMP: wr_ok = 1'b1;
`ifdef YSYX_23060236_CLINT_MTIME_WR_EN
      REG_MTIME:    wr_ok = 1'b1;
`endif
      default:      wr_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (awvalid && wvalid) w_state_next = W_RESP;
      W_RESP:  if (bready)            w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // ---------------- register next-state ----------------
  always_comb begin
    msip_next = msip_reg;
    for (int h = 0; h < NHART; h++) mtimecmp_next[h] = mtimecmp_reg[h];
    mtime_next = mtime_reg;
    presc_next = presc_reg;

    if (presc_reg == DIV_LAST) begin
      mtime_next = mtime_reg + 64'd1;
      presc_next = 8'd0;
    end else begin
      presc_next = presc_reg + 8'd1;
    end

    if (wr_fire && wr_ok) begin
      case (wr_sel.kind)
        REG_MSIP: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_sel.hart == 2'(h) && wstrb[0]) msip_next[h] = wdata[0];
          end
        end
        REG_MTIMECMP: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_sel.hart == 2'(h)) begin
              if (wr_sel.hi)
                mtimecmp_next[h][63:32] = merge_bytes(mtimecmp_reg[h][63:32], wdata, wstrb);
              else
                mtimecmp_next[h][31:0] = merge_bytes(mtimecmp_reg[h][31:0], wdata, wstrb);
            end
          end
        end
`ifdef YSYX_23060236_CLINT_MTIME_WR_EN
        REG_MTIME: begin
          // The written value replaces the increment entirely; the untouched
          // half keeps its pre-increment value and the prescaler restarts.
          if (wr_sel.hi)
            mtime_next = {merge_bytes(mtime_reg[63:32], wdata, wstrb), mtime_reg[31:0]};
          else
            mtime_next = {mtime_reg[63:32], merge_bytes(mtime_reg[31:0], wdata, wstrb)};
          presc_next = 8'd0;
        end
`endif
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NHART; gi++) begin : g_hart
    assign mtip_hit[gi] = (mtime_reg >= mtimecmp_reg[gi]);
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_reg <= R_IDLE;
      w_state_reg <= W_IDLE;
      mtime_reg   <= '0;
      presc_reg   <= '0;
      for (int h = 0; h < NHART; h++) mtimecmp_reg[h] <= '1;
      msip_reg    <= '0;
      mtip_reg    <= '0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
      bresp_reg   <= RESP_OKAY;
    end else begin
      r_state_reg <= r_state_next;
      w_state_reg <= w_state_next;
      mtime_reg   <= mtime_next;
      presc_reg   <= presc_next;
      for (int h = 0; h < NHART; h++) mtimecmp_reg[h] <= mtimecmp_next[h];
      msip_reg    <= msip_next;
      mtip_reg    <= mtip_hit;
      if (rd_fire) begin
        rdata_reg <= rd_word;
        rresp_reg <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (wr_fire) begin
        bresp_reg <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------- outputs ----------------
  assign arready = (r_state_reg == R_IDLE);
  assign rvalid  = (r_state_reg == R_RESP);
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;
  assign awready = wr_fire;
  assign wready  = wr_fire;
  assign bvalid  = (w_state_reg == W_RESP);
  assign bresp   = bresp_reg;
  assign mtip    = mtip_reg;
  assign msip    = msip_reg;

endmodule
